// File: rtl/scarv_cop_cpr_wb_pkg.sv
// Shared definitions for the coprocessor CPR file and writeback stage.
// Provides the default register count, address/data/byte-enable widths,
// the write-port source encoding and the byte-merge helper used by both the
// register array and the pending-buffer forwarding path.
package scarv_cop_cpr_wb_pkg;

    localparam int CPR_COUNT_DEFAULT = 16;
    localparam int CPR_AW            = $clog2(CPR_COUNT_DEFAULT);
    localparam int CPR_XLEN          = 32;
    localparam int CPR_BEN_W         = CPR_XLEN / 8;

    typedef logic [CPR_XLEN-1:0]  cpr_word_t;
    typedef logic [CPR_BEN_W-1:0] cpr_ben_t;

    // Which writer owns the single physical write port this cycle.
    typedef enum logic [1:0] {
        WSRC_NONE = 2'd0,
        WSRC_PALU = 2'd1,
        WSRC_PEND = 2'd2,
        WSRC_MEM  = 2'd3
    } wsrc_e;

    // Replace the bytes of old_w selected by ben with the bytes of new_w.
    function automatic cpr_word_t byte_merge(cpr_word_t old_w, cpr_word_t new_w, cpr_ben_t ben);
        cpr_word_t r;
        for (int b = 0; b < CPR_BEN_W; b++) begin
            r[8*b +: 8] = ben[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/scarv_cop_cpr_wb_pending.sv
// One-entry pending buffer for memory-unit writes that lost the write port
// to a same-cycle PALU write.
// Ports:
//   g_clk, g_resetn      clock, async active-low reset
//   palu_act, palu_rd,   effective PALU write this cycle (used for drain
//   palu_ben             blocking and for killing overlapping pending bytes)
//   capture, cap_*       latch a memory write into the buffer
//   rd_addr, rd_raw      three read ports: address and array data
//   rd_fwd               read data with pending bytes overlaid
//   pend_valid           buffer holds at least one live byte
//   drain                buffer owns the write port this cycle
//   pend_rd/ben/data     buffer contents, for the drain write
module scarv_cop_cpr_wb_pending
    import scarv_cop_cpr_wb_pkg::*;
#(
    parameter int AW = CPR_AW
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    input  logic                 palu_act,
    input  logic [AW-1:0]        palu_rd,
    input  cpr_ben_t             palu_ben,
    input  logic                 capture,
    input  logic [AW-1:0]        cap_rd,
    input  cpr_ben_t             cap_ben,
    input  cpr_word_t            cap_data,
    input  logic [2:0][AW-1:0]   rd_addr,
    input  cpr_word_t [2:0]      rd_raw,
    output cpr_word_t [2:0]      rd_fwd,
    output logic                 pend_valid,
    output logic                 drain,
    output logic [AW-1:0]        pend_rd,
    output cpr_ben_t             pend_ben,
    output cpr_word_t            pend_data
);

    // Validity is carried entirely by the byte enables: ben == 0 means empty.
    cpr_ben_t      ben_q, ben_d;
    logic [AW-1:0] rd_q;
    cpr_word_t     data_q;
    logic          kill_hit;

    assign pend_valid = |ben_q;
    assign drain      = pend_valid && !palu_act;
    assign kill_hit   = pend_valid && palu_act && (palu_rd == rd_q);

    assign pend_rd    = rd_q;
    assign pend_ben   = ben_q;
    assign pend_data  = data_q;

    always_comb begin
        ben_d = ben_q;
        if (capture) begin
            ben_d = cap_ben;
        end else if (drain) begin
            ben_d = '0;
        end else if (kill_hit) begin
            // The PALU write is younger: its bytes supersede the pending ones,
            // and an all-killed entry simply vanishes without a drain cycle.
            ben_d = ben_q & ~palu_ben;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            ben_q <= '0;
        end else begin
            ben_q <= ben_d;
        end
    end

    // Address and data are qualified by ben_q, so they need no reset.
    always_ff @(posedge g_clk) begin
        if (capture) begin
            rd_q   <= cap_rd;
            data_q <= cap_data;
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rd_fwd[i] = rd_raw[i];
            if (pend_valid && (rd_addr[i] == rd_q)) begin
                rd_fwd[i] = byte_merge(rd_raw[i], data_q, ben_q);
            end
        end
    end

endmodule

// File: rtl/scarv_cop_cpr_wb.sv
// Coprocessor general-purpose register file and writeback stage.
// A single physical write port is shared by the PALU (highest priority), a
// one-entry pending buffer, and the memory/load unit. Three combinational
// read ports forward pending-buffer bytes so readers see ordered values.
// Ports:
//   g_clk, g_resetn                 clock, async active-low reset
//   palu_wen/rd/ben/wdata           PALU writeback
//   mem_wvalid/wready/rd/ben/wdata  memory-unit write handshake
//   rs1/2/3_addr, rs1/2/3_data      read operands
//   wb_pending                      pending buffer is occupied
module scarv_cop_cpr_wb
    import scarv_cop_cpr_wb_pkg::*;
#(
    parameter int  CPR_COUNT = CPR_COUNT_DEFAULT,
    parameter bit  C0_ZERO   = 1'b1,
    localparam int AW        = $clog2(CPR_COUNT)
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          palu_wen,
    input  logic [AW-1:0] palu_rd,
    input  logic [3:0]    palu_ben,
    input  logic [31:0]   palu_wdata,
    input  logic          mem_wvalid,
    output logic          mem_wready,
    input  logic [AW-1:0] mem_rd,
    input  logic [3:0]    mem_ben,
    input  logic [31:0]   mem_wdata,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    input  logic [AW-1:0] rs3_addr,
    output logic [31:0]   rs1_data,
    output logic [31:0]   rs2_data,
    output logic [31:0]   rs3_data,
    output logic          wb_pending
);

    cpr_word_t          cpr [CPR_COUNT];

    logic               palu_act;
    logic               mem_acc;
    logic               mem_keep;
    logic               capture;
    logic               pend_valid;
    logic               drain;
    logic [AW-1:0]      pend_rd;
    cpr_ben_t           pend_ben;
    cpr_word_t          pend_data;

    wsrc_e              wr_src;
    logic [AW-1:0]      wr_rd;
    cpr_ben_t           wr_ben;
    cpr_word_t          wr_data;

    logic [2:0][AW-1:0] rs_addr;
    cpr_word_t [2:0]    rs_raw;
    cpr_word_t [2:0]    rs_fwd;

    // Writes that cannot change state (no bytes, or aimed at a hardwired c0)
    // are filtered here so they neither occupy the port nor enter pending.
    assign palu_act = palu_wen && (palu_ben != '0) && !(C0_ZERO && (palu_rd == '0));
    assign mem_acc  = mem_wvalid && mem_wready;
    assign mem_keep = mem_acc && (mem_ben != '0) && !(C0_ZERO && (mem_rd == '0));
    assign capture  = mem_keep && palu_act;

    // Depends only on registered pending state, never on this cycle's valids.
    assign mem_wready = !pend_valid;
    assign wb_pending = pend_valid;

    always_comb begin
        wr_src  = WSRC_NONE;
        wr_rd   = '0;
        wr_ben  = '0;
        wr_data = '0;
        if (palu_act) begin
            wr_src  = WSRC_PALU;
            wr_rd   = palu_rd;
            wr_ben  = palu_ben;
            wr_data = palu_wdata;
        end else if (drain) begin
            wr_src  = WSRC_PEND;
            wr_rd   = pend_rd;
            wr_ben  = pend_ben;
            wr_data = pend_data;
        end else if (mem_keep) begin
            wr_src  = WSRC_MEM;
            wr_rd   = mem_rd;
            wr_ben  = mem_ben;
            wr_data = mem_wdata;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int i = 0; i < CPR_COUNT; i++) begin
                cpr[i] <= '0;
            end
        end else if (wr_src != WSRC_NONE) begin
            cpr[wr_rd] <= byte_merge(cpr[wr_rd], wr_data, wr_ben);
        end
    end

    assign rs_addr = {rs3_addr, rs2_addr, rs1_addr};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rs_raw[i] = (C0_ZERO && (rs_addr[i] == '0)) ? '0 : cpr[rs_addr[i]];
        end
    end

    scarv_cop_cpr_wb_pending #(
        .AW (AW)
    ) u_pending (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .palu_act   (palu_act),
        .palu_rd    (palu_rd),
        .palu_ben   (palu_ben),
        .capture    (capture),
        .cap_rd     (mem_rd),
        .cap_ben    (mem_ben),
        .cap_data   (mem_wdata),
        .rd_addr    (rs_addr),
        .rd_raw     (rs_raw),
        .rd_fwd     (rs_fwd),
        .pend_valid (pend_valid),
        .drain      (drain),
        .pend_rd    (pend_rd),
        .pend_ben   (pend_ben),
        .pend_data  (pend_data)
    );

    assign rs1_data = rs_fwd[0];
    assign rs2_data = rs_fwd[1];
    assign rs3_data = rs_fwd[2];

endmodule

// File: tb/tb_scarv_cop_cpr_wb.sv
// Scoreboard bench for scarv_cop_cpr_wb: the stimulus process pushes the
// values expected during each cycle, a monitor pops and compares them on the
// falling clock edge.
module tb_scarv_cop_cpr_wb;

    localparam int SEL_RS1 = 0;
    localparam int SEL_RS2 = 1;
    localparam int SEL_RS3 = 2;
    localparam int SEL_PND = 3;
    localparam int SEL_RDY = 4;

    logic        g_clk;
    logic        g_resetn;
    logic        palu_wen;
    logic [3:0]  palu_rd;
    logic [3:0]  palu_ben;
    logic [31:0] palu_wdata;
    logic        mem_wvalid;
    logic        mem_wready;
    logic [3:0]  mem_rd;
    logic [3:0]  mem_ben;
    logic [31:0] mem_wdata;
    logic [3:0]  rs1_addr, rs2_addr, rs3_addr;
    logic [31:0] rs1_data, rs2_data, rs3_data;
    logic        wb_pending;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    scarv_cop_cpr_wb #(
        .CPR_COUNT (16),
        .C0_ZERO   (1'b1)
    ) dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .palu_wen   (palu_wen),
        .palu_rd    (palu_rd),
        .palu_ben   (palu_ben),
        .palu_wdata (palu_wdata),
        .mem_wvalid (mem_wvalid),
        .mem_wready (mem_wready),
        .mem_rd     (mem_rd),
        .mem_ben    (mem_ben),
        .mem_wdata  (mem_wdata),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs3_addr   (rs3_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rs3_data   (rs3_data),
        .wb_pending (wb_pending)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    initial begin
        #100000;
        n_checks++;
        n_fail++;
        $display("FAIL timeout: test did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    function automatic logic [31:0] actual(int sel);
        case (sel)
            SEL_RS1: return rs1_data;
            SEL_RS2: return rs2_data;
            SEL_RS3: return rs3_data;
            SEL_PND: return {31'd0, wb_pending};
            default: return {31'd0, mem_wready};
        endcase
    endfunction

    // Monitor: outputs are combinational and valid all cycle; compare mid-cycle.
    always @(negedge g_clk) begin
        while (q.size() > 0) begin
            chk_t c;
            logic [31:0] a;
            c = q.pop_front();
            a = actual(c.sel);
            n_checks++;
            if (a !== c.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", c.name, a, c.exp);
            end
        end
    end

    task automatic check_now(string nm, int sel, logic [31:0] v);
        logic [31:0] a;
        a = actual(sel);
        n_checks++;
        if (a !== v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (immediate)", nm, a, v);
        end
    endtask

    task automatic expect_v(string nm, int sel, logic [31:0] v);
        q.push_back('{nm, sel, v});
    endtask

    task automatic cyc();
        @(posedge g_clk);
        #1;
    endtask

    task automatic palu(logic en, logic [3:0] rd, logic [3:0] ben, logic [31:0] d);
        palu_wen   = en;
        palu_rd    = rd;
        palu_ben   = ben;
        palu_wdata = d;
    endtask

    task automatic mem(logic en, logic [3:0] rd, logic [3:0] ben, logic [31:0] d);
        mem_wvalid = en;
        mem_rd     = rd;
        mem_ben    = ben;
        mem_wdata  = d;
    endtask

    task automatic rs(logic [3:0] a1, logic [3:0] a2, logic [3:0] a3);
        rs1_addr = a1;
        rs2_addr = a2;
        rs3_addr = a3;
    endtask

    initial begin
        g_resetn = 1'b0;
        palu(0, 0, 0, 0);
        mem(0, 0, 0, 0);
        rs(0, 0, 0);
        repeat (2) @(posedge g_clk);
        #1;
        g_resetn = 1'b1;

        // Reset state
        rs(3, 5, 7);
        #1;
        check_now("reset_rs1", SEL_RS1, 32'h0);
        check_now("reset_rs2", SEL_RS2, 32'h0);
        check_now("reset_rs3", SEL_RS3, 32'h0);
        check_now("reset_pending", SEL_PND, 32'h0);
        check_now("reset_wready", SEL_RDY, 32'h1);

        // Byte merge
        cyc();
        palu(1, 3, 4'b0011, 32'hAABBCCDD);
        cyc();
        palu(1, 3, 4'b1100, 32'h11223344);
        expect_v("merge_lo", SEL_RS1, 32'h0000CCDD);
        cyc();
        palu(0, 0, 0, 0);
        expect_v("merge_hi", SEL_RS1, 32'h1122CCDD);

        // Collision on the same register: MEM wins once drained
        cyc();
        palu(1, 5, 4'hF, 32'h1);
        mem(1, 5, 4'hF, 32'h2);
        expect_v("coll_wready_before", SEL_RDY, 32'h1);
        cyc();
        palu(0, 0, 0, 0);
        mem(0, 0, 0, 0);
        expect_v("coll_pending", SEL_PND, 32'h1);
        expect_v("coll_wready_low", SEL_RDY, 32'h0);
        expect_v("coll_fwd", SEL_RS2, 32'h2);
        cyc();
        expect_v("coll_drained", SEL_PND, 32'h0);
        expect_v("coll_wready_back", SEL_RDY, 32'h1);
        expect_v("coll_array", SEL_RS2, 32'h2);

        // Kill of pending bytes by younger PALU writes
        cyc();
        palu(1, 8, 4'hF, 32'h12345678);
        mem(1, 7, 4'b0011, 32'h0000BEEF);
        cyc();
        palu(1, 7, 4'b0001, 32'hFFFFFF00);
        mem(0, 0, 0, 0);
        rs(8, 5, 7);
        expect_v("kill_pending0", SEL_PND, 32'h1);
        expect_v("kill_fwd0", SEL_RS3, 32'h0000BEEF);
        expect_v("kill_other_rd", SEL_RS1, 32'h12345678);
        cyc();
        palu(1, 7, 4'b0010, 32'hFFFFFF00);
        expect_v("kill_pending1", SEL_PND, 32'h1);
        expect_v("kill_partial", SEL_RS3, 32'h0000BE00);
        cyc();
        palu(0, 0, 0, 0);
        expect_v("kill_invalid", SEL_PND, 32'h0);
        expect_v("kill_wready", SEL_RDY, 32'h1);
        expect_v("kill_no_drain", SEL_RS3, 32'h0000FF00);

        // Stall under continuous PALU writes
        cyc();
        palu(1, 9, 4'hF, 32'hA);
        mem(1, 10, 4'hF, 32'hCAFEF00D);
        for (int i = 0; i < 5; i++) begin
            cyc();
            palu(1, 9, 4'hF, 32'(i));
            mem(1, 11, 4'hF, 32'h55);
            expect_v($sformatf("stall_wready_%0d", i), SEL_RDY, 32'h0);
            expect_v($sformatf("stall_pending_%0d", i), SEL_PND, 32'h1);
        end
        cyc();
        palu(0, 0, 0, 0);
        expect_v("stall_idle_pending", SEL_PND, 32'h1);
        expect_v("stall_idle_wready", SEL_RDY, 32'h0);
        cyc();
        rs(10, 11, 9);
        expect_v("stall_drained", SEL_PND, 32'h0);
        expect_v("stall_wready_back", SEL_RDY, 32'h1);
        expect_v("stall_array", SEL_RS1, 32'hCAFEF00D);
        expect_v("stall_palu_last", SEL_RS3, 32'h4);
        cyc();
        mem(0, 0, 0, 0);
        expect_v("mem_direct", SEL_RS2, 32'h55);
        expect_v("mem_direct_nopend", SEL_PND, 32'h0);

        // c0 writes are dropped
        cyc();
        palu(1, 0, 4'hF, 32'hFFFFFFFF);
        mem(1, 0, 4'hF, 32'h77);
        rs(0, 11, 9);
        expect_v("c0_wready", SEL_RDY, 32'h1);
        cyc();
        palu(0, 0, 0, 0);
        mem(0, 0, 0, 0);
        expect_v("c0_read", SEL_RS1, 32'h0);
        expect_v("c0_no_pending", SEL_PND, 32'h0);

        // Zero byte-enable PALU write does not block the drain
        cyc();
        palu(1, 12, 4'hF, 32'h1);
        mem(1, 13, 4'hF, 32'h13);
        cyc();
        palu(1, 13, 4'h0, 32'hFFFFFFFF);
        mem(0, 0, 0, 0);
        rs(13, 12, 0);
        expect_v("ben0_pending", SEL_PND, 32'h1);
        cyc();
        palu(0, 0, 0, 0);
        expect_v("ben0_drained", SEL_PND, 32'h0);
        expect_v("ben0_array", SEL_RS1, 32'h13);

        // Asynchronous reset while pending
        cyc();
        palu(1, 14, 4'hF, 32'h14);
        mem(1, 15, 4'hF, 32'h00000F15);
        cyc();
        palu(1, 14, 4'hF, 32'h14);
        mem(0, 0, 0, 0);
        rs(15, 14, 3);
        expect_v("ar_pending_before", SEL_PND, 32'h1);
        expect_v("ar_fwd_before", SEL_RS1, 32'h00000F15);
        expect_v("ar_wready_before", SEL_RDY, 32'h0);
        cyc();
        #1;
        g_resetn = 1'b0;
        #1;
        check_now("ar_pending", SEL_PND, 32'h0);
        check_now("ar_wready", SEL_RDY, 32'h1);
        check_now("ar_rs1", SEL_RS1, 32'h0);
        check_now("ar_rs2", SEL_RS2, 32'h0);
        check_now("ar_rs3", SEL_RS3, 32'h0);
        cyc();
        g_resetn = 1'b1;
        palu(0, 0, 0, 0);
        cyc();
        expect_v("ar_after_rs2", SEL_RS2, 32'h0);
        expect_v("ar_after_pending", SEL_PND, 32'h0);

        @(negedge g_clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
